// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and widths for the sequential shift unit.
package shift_seq_pkg;
   localparam int XLEN = 64;
   localparam int SHAMT_W = $clog2(XLEN);
   typedef enum logic [1:0] {SLL = 2'd0, SRL = 2'd1, SRA = 2'd2} shift_op_t;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t;
endpackage

// File: rtl/shift_seq_unit_if.sv
// shift_seq_unit_if: request/result handshake bundle of the sequential shift unit.
interface shift_seq_unit_if #(parameter int XLEN = 64);
   import shift_seq_pkg::*;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         in_op;
   logic               in_word;
   logic [XLEN-1:0]    in_operand;
   logic [SHAMT_W-1:0] in_amount;
   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    out_result;
   logic               busy;
   modport master (
      output in_valid, in_op, in_word, in_operand, in_amount, out_ready,
      input  in_ready, out_valid, out_result, busy
   );
   modport slave (
      input  in_valid, in_op, in_word, in_operand, in_amount, out_ready,
      output in_ready, out_valid, out_result, busy
   );
endinterface

// File: rtl/shift_seq_unit_step.sv
// shift_step: one narrow shift stage, 0..STEP positions with op-dependent fill.
module shift_step #(
   parameter int XLEN = 64,
   parameter int STEP = 8,
   localparam int AW = $clog2(STEP) + 1
) (
   input  logic [XLEN-1:0] data_i,
   input  logic [AW-1:0]   amt_i,
   input  logic [1:0]      op_i,
   output logic [XLEN-1:0] data_o
);
   import shift_seq_pkg::*;
   logic [XLEN-1:0] sra_w;
   // kept separate so the arithmetic shift stays in a signed context
   assign sra_w = $signed(data_i) >>> amt_i;
   always_comb data_o = (op_i == SLL) ? data_i << amt_i : (op_i == SRA) ? sra_w : data_i >> amt_i;
endmodule

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: multi-cycle RV64 shifter (SLL/SRL/SRA and W forms), STEP bits per cycle.
// Optional synchronous flush input when SHIFT_SEQ_FLUSH_EN is defined.
module shift_seq_unit #(
   parameter int XLEN = 64,
   parameter int STEP = 8
) (
   input logic clk,
   input logic rst_n,
`ifdef SHIFT_SEQ_FLUSH_EN
   input logic flush,
`endif
   shift_seq_unit_if.slave bus
);
   import shift_seq_pkg::*;
   localparam int AW = $clog2(STEP) + 1;
   shift_state_t       state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               word_q, word_d;
   logic [XLEN-1:0]    w_q, w_d, step_w, opnd;
   logic [SHAMT_W-1:0] rem_q, rem_d, amt;
   logic [AW-1:0]      s;
   logic               flush_w;
`ifdef SHIFT_SEQ_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif
   assign amt = bus.in_word ? {1'b0, bus.in_amount[4:0]} : bus.in_amount;
   // W forms pre-extend the low word so the 64-bit stage produces the 32-bit result
   assign opnd = !bus.in_word || bus.in_op == SLL ? bus.in_operand
               : bus.in_op == SRA ? {{(XLEN-32){bus.in_operand[31]}}, bus.in_operand[31:0]}
               : {{(XLEN-32){1'b0}}, bus.in_operand[31:0]};
   assign s = (int'(rem_q) < STEP) ? AW'(rem_q) : AW'(STEP);
   assign bus.in_ready = (state_q == IDLE) && !flush_w;
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy = (state_q != IDLE);
   assign bus.out_result = word_q ? {{(XLEN-32){w_q[31]}}, w_q[31:0]} : w_q;
   shift_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
      .data_i(w_q),
      .amt_i (s),
      .op_i  (op_q),
      .data_o(step_w)
   );
   always_comb begin
      state_d = state_q;
      op_d = op_q;
      word_d = word_q;
      w_d = w_q;
      rem_d = rem_q;
      case (state_q)
         IDLE: if (bus.in_valid && bus.in_ready) begin
            op_d = bus.in_op;
            word_d = bus.in_word;
            w_d = opnd;
            rem_d = amt;
            state_d = (amt == '0) ? DONE : SHIFT;
         end
         SHIFT: begin
            w_d = step_w;
            rem_d = rem_q - SHAMT_W'(s);
            state_d = (rem_d == '0) ? DONE : SHIFT;
         end
         DONE: state_d = bus.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
      if (flush_w && state_q != IDLE) begin
         state_d = IDLE;
         rem_d = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q <= 2'd0;
         word_q <= 1'b0;
         w_q <= '0;
         rem_q <= '0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         word_q <= word_d;
         w_q <= w_d;
         rem_q <= rem_d;
      end
   end
endmodule
